mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
Sequences the moles during the PLAYING phase of the whack-a-mole game. It is gated by the game controller's mole-control enable and paced by the selected difficulty level. It picks a pseudo-random hole, raises that mole for a difficulty-dependent time, and detects a hit or a timeout. It emits one-cycle hit/miss pulses to the score counter and drives the mole LED mask.

Parameters:
NUM_HOLES, 8, number of holes; power of 2, 2..16
TICK_DIV, 100000, clk cycles per 1 ms tick
UP_MS_0, 1000, mole up-time in ms, difficulty 0
UP_MS_1, 700, mole up-time in ms, difficulty 1
UP_MS_2, 450, mole up-time in ms, difficulty 2
UP_MS_3, 300, mole up-time in ms, difficulty 3
GAP_MS, 250, all-down gap between moles, in ms
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  from game controller enable_mole_ctrl; level
difficulty_level  in  2  difficulty select, 0..3
hit_btn  in  NUM_HOLES  one-cycle pulses, one bit per hole button
mole_mask  out  NUM_HOLES  one-hot raised mole; all 0 when none is up
mole_idx  out  log2(NUM_HOLES)  index of current or last mole
hit_pulse  out  1  one-cycle pulse: correct hole hit
miss_pulse  out  1  one-cycle pulse: mole timed out
mole_count  out  8  moles raised since enable rose; saturates at 255

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = LFSR_SEED; prescaler and ms counter 0.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Free-runs every clk cycle, regardless of state.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits a tick on the terminal count.
  - Prescaler and ms counter clear on entry to GAP and to UP, so durations are exact.
- States:
  - IDLE: mask 0. When enable=1, go to GAP next cycle and clear mole_count.
  - GAP: mask 0. On the tick where ms counter = GAP_MS-1, go to PICK.
    - GAP lasts exactly GAP_MS*TICK_DIV cycles.
  - PICK (1 cycle):
    - Candidate = LFSR[log2(NUM_HOLES)-1:0].
    - If the candidate equals the previous mole_idx and mole_count>0, use candidate+1 modulo NUM_HOLES.
    - Latch the index and the up-time from difficulty_level.
    - Go to UP.
  - UP:
    - mole_mask = one-hot(mole_idx), registered, asserted from the first UP cycle.
    - mole_count increments by 1 on UP entry, saturating at 255.
    - UP lasts at most up_time*TICK_DIV cycles.
- Hit in UP:
  - Condition: hit_btn[mole_idx]=1 in any UP cycle.
  - Next cycle: hit_pulse=1 for one cycle, mask=0, state=GAP.
  - Presses on other holes are ignored, with no penalty. A multi-bit hit_btn containing the mole's bit counts as a hit.
- Timeout in UP:
  - Condition: the tick where ms counter = up_time-1 with no hit.
  - Next cycle: miss_pulse=1 for one cycle, mask=0, state=GAP.
- Simultaneous hit and timeout in the same cycle: hit wins; miss_pulse stays 0.
- hit_pulse and miss_pulse are never both 1, and each lasts exactly one cycle.
- hit_btn outside UP is ignored.
- Difficulty change mid-mole takes effect at the next PICK.
- enable falls in any state:
  - Next cycle: state=IDLE, mask=0, no hit/miss pulse issued.
  - mole_idx and mole_count hold their values.
  - Counters clear.
- enable re-rise restarts from GAP with mole_count cleared.
- Async reset mid-operation returns everything to reset values immediately.
- Widths:
  - ms counter is 10 bits; all UP_MS_* and GAP_MS must be ≤1023.
  - Prescaler width is log2(TICK_DIV), rounded up.

Test Plan:
- Reset, then enable=1 (TICK_DIV=4, GAP_MS=2) -> mask=0 for exactly 8 cycles in GAP plus 1 PICK cycle, then mask one-hot, mole_count=1.
- Difficulty 3 (UP_MS_3=3, TICK_DIV=4), no press -> mask held exactly 12 cycles, then miss_pulse high 1 cycle, mask=0, next mole follows after the gap.
- During UP with mole_idx=5, pulse hit_btn=8'h08, then hit_btn=8'h20 -> first press ignored; one cycle after the second press hit_btn_pulse... hit_pulse=1 for 1 cycle, mask=0, miss_pulse never asserted for that mole.
- hit_btn[mole_idx] pulsed on the exact timeout-tick cycle -> hit_pulse=1, miss_pulse=0.
- Drop enable mid-UP -> next cycle mask=0, no pulses; re-raise enable -> mole_count restarts at 0, then 1 at the next UP.
- Run 300 moles -> no two consecutive mole_idx values equal; every index 0..7 appears; mole_count saturates at 255.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: picks a pseudo-random hole, raises its mole for a
// difficulty-dependent time and reports hit or miss as one-cycle pulses.
module mole_scheduler #(
   parameter int          NUM_HOLES = 8,
   parameter int          TICK_DIV  = 100000,
   parameter int          UP_MS_0   = 1000,
   parameter int          UP_MS_1   = 700,
   parameter int          UP_MS_2   = 450,
   parameter int          UP_MS_3   = 300,
   parameter int          GAP_MS    = 250,
   parameter logic [7:0]  LFSR_SEED = 8'hA5,
   localparam int         IW        = $clog2(NUM_HOLES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [1:0]           difficulty_level,
   input  logic [NUM_HOLES-1:0] hit_btn,
   output logic [NUM_HOLES-1:0] mole_mask,
   output logic [IW-1:0]        mole_idx,
   output logic                 hit_pulse,
   output logic                 miss_pulse,
   output logic [7:0]           mole_count
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, GAP, PICK, UP} state_t;

   state_t        state;
   logic [7:0]    lfsr;
   logic [7:0]    lfsr_next;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_next;
   logic [9:0]    ms;
   logic [9:0]    ms_next;
   logic [9:0]    up_ms;
   logic [9:0]    up_sel;
   logic          tick;
   logic          gap_done;
   logic          timeout;
   logic          hit;
   logic [IW-1:0] cand;
   logic [IW-1:0] pick_idx;

   // Galois LFSR for x^8+x^6+x^5+x^4+1; a repeated hole is bumped to its neighbour
   always_comb begin
      lfsr_next  = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      tick       = (presc == PW'(TICK_DIV - 1));
      presc_next = tick ? '0 : presc + PW'(1);
      ms_next    = tick ? ms + 10'd1 : ms;
      gap_done   = tick && (ms == 10'(GAP_MS - 1));
      timeout    = tick && (ms == up_ms - 10'd1);
      hit        = hit_btn[mole_idx];
      cand       = lfsr[IW-1:0];
      pick_idx   = (cand == mole_idx && mole_count != 8'd0) ? cand + IW'(1) : cand;
      case (difficulty_level)
         2'd0:    up_sel = 10'(UP_MS_0);
         2'd1:    up_sel = 10'(UP_MS_1);
         2'd2:    up_sel = 10'(UP_MS_2);
         default: up_sel = 10'(UP_MS_3);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lfsr       <= LFSR_SEED;
         presc      <= '0;
         ms         <= '0;
         up_ms      <= '0;
         mole_mask  <= '0;
         mole_idx   <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         mole_count <= '0;
      end else begin
         lfsr       <= lfsr_next;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         if (!enable) begin
            // Dropping enable abandons the current mole silently
            state     <= IDLE;
            mole_mask <= '0;
            presc     <= '0;
            ms        <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state      <= GAP;
                  mole_count <= '0;
                  presc      <= '0;
                  ms         <= '0;
               end
               GAP: begin
                  if (gap_done) begin
                     state <= PICK;
                     presc <= '0;
                     ms    <= '0;
                  end else begin
                     presc <= presc_next;
                     ms    <= ms_next;
                  end
               end
               PICK: begin
                  state     <= UP;
                  mole_idx  <= pick_idx;
                  up_ms     <= up_sel;
                  mole_mask <= NUM_HOLES'(1) << pick_idx;
                  if (mole_count != 8'hFF) mole_count <= mole_count + 8'd1;
                  presc     <= '0;
                  ms        <= '0;
               end
               UP: begin
                  // A hit on the timeout tick still counts as a hit
                  if (hit) begin
                     hit_pulse <= 1'b1;
                     mole_mask <= '0;
                     state     <= GAP;
                     presc     <= '0;
                     ms        <= '0;
                  end else if (timeout) begin
                     miss_pulse <= 1'b1;
                     mole_mask  <= '0;
                     state      <= GAP;
                     presc      <= '0;
                     ms         <= '0;
                  end else begin
                     presc <= presc_next;
                     ms    <= ms_next;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler with a fast tick: LFSR model predicts each mole,
// a queue of expected hit/miss results is matched against the output pulses.
module tb_mole_scheduler;

   localparam int         NH   = 8;
   localparam int         IW   = 3;
   localparam logic [7:0] SEED = 8'hA5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [1:0]    difficulty_level = 2'd0;
   logic [NH-1:0] hit_btn = '0;
   logic [NH-1:0] mole_mask;
   logic [IW-1:0] mole_idx;
   logic          hit_pulse;
   logic          miss_pulse;
   logic [7:0]    mole_count;

   int total = 0;
   int bad = 0;

   bit            exp_q[$];
   logic [7:0]    m_lfsr = SEED;
   logic [7:0]    prev_lfsr = SEED;
   int            m_count = 0;
   logic [IW-1:0] m_last_idx = '0;
   logic [NH-1:0] mask_prev = '0;

   typedef struct {
      logic [1:0] diff;
      int         press_at;
      bit         decoy;
      int         up_len;
   } vec_t;

   vec_t vecs[8];

   mole_scheduler #(
      .NUM_HOLES (NH),
      .TICK_DIV  (4),
      .UP_MS_0   (6),
      .UP_MS_1   (5),
      .UP_MS_2   (4),
      .UP_MS_3   (3),
      .GAP_MS    (2),
      .LFSR_SEED (SEED)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .difficulty_level (difficulty_level),
      .hit_btn          (hit_btn),
      .mole_mask        (mole_mask),
      .mole_idx         (mole_idx),
      .hit_pulse        (hit_pulse),
      .miss_pulse       (miss_pulse),
      .mole_count       (mole_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [7:0] lfsrStep(input logic [7:0] l);
      logic       fb;
      logic [7:0] r;
      fb = l[0];
      r  = l >> 1;
      if (fb) r = r ^ 8'b1011_1000;
      return r;
   endfunction

   function automatic logic [NH-1:0] onehot(input logic [IW-1:0] i);
      logic [NH-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [1:0] diff, input logic [NH-1:0] hb);
      enable           = en;
      difficulty_level = diff;
      hit_btn          = hb;
   endtask

   // One clock: advance the LFSR model, match pulses against the queue, predict new moles
   task automatic step();
      logic [IW-1:0] cand;
      bit            e;
      @(negedge clk);
      if (!rst_n) begin
         m_lfsr    = SEED;
         prev_lfsr = SEED;
      end else begin
         prev_lfsr = m_lfsr;
         m_lfsr    = lfsrStep(m_lfsr);
      end
      if (hit_pulse || miss_pulse) begin
         checkOutput("pulse_exclusive", int'(hit_pulse & miss_pulse), 0);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse", int'({hit_pulse, miss_pulse}), 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("pulse_kind", int'({hit_pulse, miss_pulse}), e ? 2 : 1);
         end
      end
      if (mole_mask != '0 && mask_prev == '0) begin
         cand = prev_lfsr[IW-1:0];
         if (cand == m_last_idx && m_count > 0) cand = cand + 3'd1;
         m_count    = (m_count < 255) ? m_count + 1 : 255;
         m_last_idx = cand;
         checkOutput("mole_idx", int'(mole_idx), int'(cand));
         checkOutput("mole_mask", int'(mole_mask), int'(onehot(cand)));
         checkOutput("mole_count", int'(mole_count), m_count);
      end
      mask_prev = mole_mask;
   endtask

   task automatic waitMole(output int n);
      n = 0;
      while (mole_mask == '0 && n < 60) begin
         step();
         n++;
      end
      if (mole_mask == '0) checkOutput("mole_wait_expired", 0, 1);
   endtask

   // Drives one raised mole until it goes down; returns how many cycles it stayed up
   task automatic runMole(input int press_at, input bit decoy, input bit change_diff, output int len);
      logic [IW-1:0] idx;
      logic [IW-1:0] other;
      logic [NH-1:0] hb;
      int            c;
      idx   = m_last_idx;
      other = idx + 3'd6;
      if (press_at < 0) exp_q.push_back(1'b0);
      c = 0;
      while (mole_mask != '0 && c < 100) begin
         hb = '0;
         if (c == press_at) begin
            hb = onehot(idx);
            exp_q.push_back(1'b1);
         end else if (c == 0 && decoy) begin
            hb = onehot(other);
         end
         if (change_diff && c == 1) difficulty_level = ~difficulty_level;
         hit_btn = hb;
         step();
         hit_btn = '0;
         c++;
      end
      len = c;
   endtask

   initial begin
      int            n;
      int            len;
      int            dups;
      logic [NH-1:0] seen;
      logic [IW-1:0] last;

      vecs[0] = '{2'd3, -1, 1'b0, 12};
      vecs[1] = '{2'd0, -1, 1'b0, 24};
      vecs[2] = '{2'd1,  2, 1'b0, 3};
      vecs[3] = '{2'd2,  0, 1'b0, 1};
      vecs[4] = '{2'd3, 11, 1'b0, 12};
      vecs[5] = '{2'd2, -1, 1'b1, 16};
      vecs[6] = '{2'd1,  5, 1'b1, 6};
      vecs[7] = '{2'd0, 23, 1'b0, 24};

      // Reset values
      step();
      step();
      checkOutput("reset_mask", int'(mole_mask), 0);
      checkOutput("reset_idx", int'(mole_idx), 0);
      checkOutput("reset_hit", int'(hit_pulse), 0);
      checkOutput("reset_miss", int'(miss_pulse), 0);
      checkOutput("reset_count", int'(mole_count), 0);
      rst_n = 1'b1;
      step();
      checkOutput("idle_mask", int'(mole_mask), 0);

      // Start: stray presses during GAP, then 8 GAP + 1 PICK cycles before the first mole
      applyStimulus(1'b1, vecs[0].diff, '1);
      m_count = 0;
      for (int i = 0; i < 3; i++) step();
      hit_btn = '0;
      waitMole(n);
      checkOutput("start_delay", n + 3, 10);

      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            difficulty_level = vecs[i].diff;
            waitMole(n);
            checkOutput("gap_delay", n, 9);
         end
         runMole(vecs[i].press_at, vecs[i].decoy, 1'b1, len);
         checkOutput("up_len", len, vecs[i].up_len);
      end

      // Enable dropped mid-UP together with a correct press
      difficulty_level = 2'd0;
      waitMole(n);
      checkOutput("gap_delay", n, 9);
      step();
      step();
      applyStimulus(1'b0, 2'd0, onehot(m_last_idx));
      step();
      hit_btn = '0;
      checkOutput("drop_mask", int'(mole_mask), 0);
      checkOutput("drop_pulses", int'({hit_pulse, miss_pulse}), 0);
      checkOutput("drop_idx_held", int'(mole_idx), int'(m_last_idx));
      checkOutput("drop_count_held", int'(mole_count), m_count);
      for (int i = 0; i < 3; i++) step();
      checkOutput("idle_after_drop", int'(mole_mask), 0);
      applyStimulus(1'b1, 2'd0, '0);
      m_count = 0;
      step();
      checkOutput("restart_count", int'(mole_count), 0);
      waitMole(n);
      checkOutput("restart_delay", n, 9);
      runMole(-1, 1'b0, 1'b0, len);
      checkOutput("up_len", len, 24);

      // Asynchronous reset in the middle of a mole
      waitMole(n);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_mask", int'(mole_mask), 0);
      checkOutput("async_idx", int'(mole_idx), 0);
      checkOutput("async_count", int'(mole_count), 0);
      m_count    = 0;
      m_last_idx = '0;
      mask_prev  = '0;
      exp_q.delete();
      step();
      rst_n = 1'b1;
      difficulty_level = 2'd3;
      waitMole(n);
      checkOutput("post_reset_delay", n, 10);

      // Long run: no back-to-back repeats, every hole used, counter saturates
      dups = 0;
      seen = '0;
      last = mole_idx;
      seen[mole_idx] = 1'b1;
      runMole(0, 1'b0, 1'b0, len);
      for (int k = 1; k < 300; k++) begin
         waitMole(n);
         if (mole_idx == last) dups++;
         last = mole_idx;
         seen[mole_idx] = 1'b1;
         runMole(k % 3, 1'b0, 1'b0, len);
      end
      checkOutput("no_repeat", dups, 0);
      checkOutput("all_holes", int'(seen), 255);
      checkOutput("count_saturated", int'(mole_count), 255);
      checkOutput("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
